// File: rtl/mk_search_sched.sv
// Two-requester round-robin scheduler for a 4-bit pattern search over an 8-bit word.
// One offset is compared per cycle; the match count is presented until the consumer takes it.
module mk_search_sched #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_a_valid,
    input  logic [3:0]       req_a_str,
    input  logic [7:0]       req_a_data,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [3:0]       req_b_str,
    input  logic [7:0]       req_b_data,
    output logic             req_b_ready,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       off_reg;
    logic [3:0]       str_reg;
    logic [7:0]       data_reg;
    logic             id_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_b_reg;
    logic [CNT_W-1:0] res_count_reg;
    logic             res_id_reg;

    logic             grant_a, grant_b, accept, hit;
    logic [3:0]       nib;

    // On contention the requester that was not served last wins.
    assign grant_a     = req_a_valid & (~req_b_valid | last_b_reg);
    assign grant_b     = req_b_valid & (~req_a_valid | ~last_b_reg);
    assign req_a_ready = RST_N & (state_reg == IDLE) & grant_a;
    assign req_b_ready = RST_N & (state_reg == IDLE) & grant_b;
    assign accept      = req_a_ready | req_b_ready;

    always_comb begin
        nib = data_reg[7:4];
        case (off_reg)
            3'd0:    nib = data_reg[3:0];
            3'd1:    nib = data_reg[4:1];
            3'd2:    nib = data_reg[5:2];
            3'd3:    nib = data_reg[6:3];
            default: nib = data_reg[7:4];
        endcase
    end

    assign hit = (nib == str_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SCAN;
            SCAN: begin
                if (abort)                state_next = IDLE;
                else if (off_reg == 3'd4) state_next = DONE;
            end
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            off_reg       <= '0;
            str_reg       <= '0;
            data_reg      <= '0;
            id_reg        <= 1'b0;
            cnt_reg       <= '0;
            last_b_reg    <= 1'b1;
            res_count_reg <= '0;
            res_id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        str_reg    <= req_b_ready ? req_b_str  : req_a_str;
                        data_reg   <= req_b_ready ? req_b_data : req_a_data;
                        id_reg     <= req_b_ready;
                        last_b_reg <= req_b_ready;
                        cnt_reg    <= '0;
                        off_reg    <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        cnt_reg <= '0;
                        off_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(hit);
                        off_reg <= (off_reg == 3'd4) ? 3'd0 : off_reg + 3'd1;
                        // Result registers only change on entry to DONE so they hold elsewhere.
                        if (off_reg == 3'd4) begin
                            res_count_reg <= cnt_reg + CNT_W'(hit);
                            res_id_reg    <= id_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign res_count = res_count_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_mk_search_sched.sv
// Bench for mk_search_sched: a cycle-level reference model with a result scoreboard,
// checked every falling edge, plus directed scenarios for arbitration, abort, back-pressure and reset.
module tb_mk_search_sched;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             req_a_valid, req_b_valid;
    logic [3:0]       req_a_str, req_b_str;
    logic [7:0]       req_a_data, req_b_data;
    logic             req_a_ready, req_b_ready;
    logic             abort, res_valid, res_ready, res_id, busy;
    logic [CNT_W-1:0] res_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: 0 idle, 1 scanning, 2 result pending.
    int m_state = 0;
    int m_off = 0;
    bit m_last_b = 1'b1;
    int m_cnt_out = 0;
    int m_id_out = 0;
    int sb_q[$];

    mk_search_sched #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_a_valid(req_a_valid), .req_a_str(req_a_str), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_str(req_b_str), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
        .abort(abort), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_count(res_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int count_matches(input logic [3:0] s, input logic [7:0] d);
        int c = 0;
        for (int k = 0; k < 5; k++)
            if (d[k +: 4] == s) c++;
        return c;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_state   <= 0;
            m_off     <= 0;
            m_last_b  <= 1'b1;
            m_cnt_out <= 0;
            m_id_out  <= 0;
            sb_q.delete();
        end else begin
            case (m_state)
                0: if (req_a_valid || req_b_valid) begin
                    if (req_b_valid && (!req_a_valid || !m_last_b)) begin
                        sb_q.push_back(16 + count_matches(req_b_str, req_b_data));
                        m_last_b <= 1'b1;
                    end else begin
                        sb_q.push_back(count_matches(req_a_str, req_a_data));
                        m_last_b <= 1'b0;
                    end
                    m_state <= 1;
                    m_off   <= 0;
                end
                1: if (abort) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_back());
                    m_state <= 0;
                end else if (m_off == 4) begin
                    if (sb_q.size() > 0) begin
                        m_cnt_out <= sb_q[0] % 16;
                        m_id_out  <= sb_q[0] / 16;
                    end
                    m_state <= 2;
                end else begin
                    m_off <= m_off + 1;
                end
                default: if (res_ready) begin
                    $display("txn: result id=%0d count=%0d", m_id_out, m_cnt_out);
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    m_state <= 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        bit ea, eb;
        ea = RST_N && m_state == 0 && req_a_valid && (!req_b_valid || m_last_b);
        eb = RST_N && m_state == 0 && req_b_valid && (!req_a_valid || !m_last_b);
        check("ready_a", req_a_ready, ea);
        check("ready_b", req_b_ready, eb);
        check("busy", busy, (RST_N && m_state != 0) ? 1 : 0);
        check("res_valid", res_valid, (RST_N && m_state == 2) ? 1 : 0);
        check("res_count", res_count, m_cnt_out);
        check("res_id", res_id, m_id_out);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic submit(input bit is_b, input logic [3:0] s, input logic [7:0] d);
        bit got = 0;
        if (is_b) begin req_b_valid = 1; req_b_str = s; req_b_data = d; end
        else      begin req_a_valid = 1; req_a_str = s; req_a_data = d; end
        for (int i = 0; i < 40; i++) begin
            #1;
            if (is_b ? req_b_ready : req_a_ready) begin got = 1; break; end
            @(negedge CLK);
            #1;
        end
        check("accept_seen", got, 1);
        @(negedge CLK);
        #1;
        if (is_b) req_b_valid = 0; else req_a_valid = 0;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!busy) begin got = 1; break; end
        end
        check("idle_seen", got, 1);
        #1;
    endtask

    initial begin
        int g[4];
        int ng, idle_n;
        bit got;

        RST_N = 0; abort = 0; res_ready = 1;
        req_a_valid = 1; req_a_str = 4'h0; req_a_data = 8'h00;
        req_b_valid = 0; req_b_str = 4'h0; req_b_data = 8'h00;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", res_count, 0);
        check("rst_id", res_id, 0);
        check("rst_ready_a", req_a_ready, 0);
        req_a_valid = 0;
        RST_N = 1;
        @(negedge CLK); #1;

        // Single-requester jobs: all-ones, one overlapping hit, no hit.
        submit(0, 4'hF, 8'hFF); wait_idle();
        submit(0, 4'hA, 8'h5A); wait_idle();
        submit(0, 4'h3, 8'h00); wait_idle();
        submit(1, 4'h0, 8'h00); wait_idle();

        // Both requesters held valid: grants must alternate starting with A.
        req_a_valid = 1; req_a_str = 4'h5; req_a_data = 8'hAA;
        req_b_valid = 1; req_b_str = 4'h0; req_b_data = 8'h0F;
        ng = 0; idle_n = 0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            #1;
            if (ng >= 1 && !busy) idle_n++;
            if (req_a_ready) begin g[ng] = 0; ng++; end
            else if (req_b_ready) begin g[ng] = 1; ng++; end
            @(negedge CLK);
        end
        check("rr_grants", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), g[i], i % 2);
        check("rr_idle_gaps", idle_n, 3);
        @(negedge CLK); #1;
        req_a_valid = 0; req_b_valid = 0;
        wait_idle();

        // Abort while the offset-2 compare is pending.
        submit(0, 4'hF, 8'hFF);
        @(negedge CLK);
        @(negedge CLK); #1;
        abort = 1;
        @(negedge CLK); #1;
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        submit(0, 4'hA, 8'h5A); wait_idle();

        // Back-pressure: result held for 10 cycles while both requesters wait.
        res_ready = 0;
        submit(1, 4'hF, 8'hFF);
        req_a_valid = 1; req_b_valid = 1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (res_valid) begin got = 1; break; end
        end
        check("hold_valid_seen", got, 1);
        repeat (10) @(negedge CLK);
        #1;
        check("hold_valid", res_valid, 1);
        check("hold_count", res_count, 5);
        check("hold_id", res_id, 1);
        check("hold_ready_a", req_a_ready, 0);
        check("hold_ready_b", req_b_ready, 0);
        req_a_valid = 0; req_b_valid = 0;
        res_ready = 1;
        wait_idle();

        // Asynchronous reset in the middle of a scan; A last served, yet A wins after reset.
        submit(0, 4'h3, 8'h33);
        @(posedge CLK); #2;
        req_a_valid = 1; req_b_valid = 1;
        RST_N = 0;
        #1;
        check("arst_res_valid", res_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_count", res_count, 0);
        check("arst_id", res_id, 0);
        check("arst_ready_a", req_a_ready, 0);
        check("arst_ready_b", req_b_ready, 0);
        @(negedge CLK);
        @(negedge CLK); #1;
        RST_N = 1;
        #1;
        check("post_rst_ready_a", req_a_ready, 1);
        check("post_rst_ready_b", req_b_ready, 0);
        @(negedge CLK); #1;
        req_a_valid = 0; req_b_valid = 0;
        wait_idle();
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
